// File: rtl/data_bus_responder.sv
// Data-memory responder: data RAM plus a 4-word MMIO window (TX FIFO, RX FIFO, STATUS, TIMER).
// Define MMIO_TIMER_EN to build the free-running TIMER register; otherwise TIMER reads 0.
module data_bus_responder #(
    parameter int ADDR_SIZE  = 18,
    parameter int WORD_SIZE  = 18,
    parameter int MEM_SIZE   = 1024,
    parameter int FIFO_DEPTH = 4,
    parameter int MMIO_BASE  = 'h3FF00
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 mem_we,
    input  logic                 mem_re,
    input  logic [ADDR_SIZE-1:0] mem_addr,
    input  logic [WORD_SIZE-1:0] mem_wdata,
    output logic [WORD_SIZE-1:0] mem_rdata,
    output logic                 tx_valid,
    output logic [WORD_SIZE-1:0] tx_data,
    input  logic                 tx_ready,
    input  logic                 rx_valid,
    input  logic [WORD_SIZE-1:0] rx_data,
    output logic                 rx_ready
);

    localparam int MEM_AW = $clog2(MEM_SIZE);
    localparam int PW     = $clog2(FIFO_DEPTH);
    localparam int CW     = PW + 1;

    localparam logic [ADDR_SIZE-1:0] TX_ADDR = ADDR_SIZE'(MMIO_BASE);
    localparam logic [ADDR_SIZE-1:0] RX_ADDR = ADDR_SIZE'(MMIO_BASE + 1);
    localparam logic [ADDR_SIZE-1:0] ST_ADDR = ADDR_SIZE'(MMIO_BASE + 2);
    localparam logic [ADDR_SIZE-1:0] TM_ADDR = ADDR_SIZE'(MMIO_BASE + 3);

    logic [WORD_SIZE-1:0] ram [MEM_SIZE];
    logic [WORD_SIZE-1:0] tx_mem [FIFO_DEPTH];
    logic [WORD_SIZE-1:0] rx_mem [FIFO_DEPTH];

    logic [PW-1:0] tx_wp, tx_rp, rx_wp, rx_rp;
    logic [CW-1:0] tx_cnt, rx_cnt;
    logic          tx_ovf, rx_unf;
    logic [WORD_SIZE-1:0] timer_val;

    logic is_ram, is_tx, is_rx, is_st, is_tm;
    logic tx_full, rx_full, rx_empty;
    logic tx_push, tx_pop, tx_ovf_evt;
    logic rx_push, rx_pop, rx_pop_req, rx_unf_evt;
    logic st_we;

    assign is_ram = mem_addr < ADDR_SIZE'(MEM_SIZE);
    assign is_tx  = mem_addr == TX_ADDR;
    assign is_rx  = mem_addr == RX_ADDR;
    assign is_st  = mem_addr == ST_ADDR;
    assign is_tm  = mem_addr == TM_ADDR;

    assign tx_full  = tx_cnt == CW'(FIFO_DEPTH);
    assign rx_full  = rx_cnt == CW'(FIFO_DEPTH);
    assign rx_empty = rx_cnt == '0;

    assign tx_valid = tx_cnt != '0;
    assign tx_data  = tx_mem[tx_rp];
    assign rx_ready = !rx_full;

    // A full TX FIFO still accepts a write when the host drains the head in the same cycle.
    assign tx_pop     = tx_valid && tx_ready;
    assign tx_push    = mem_we && is_tx && (!tx_full || tx_pop);
    assign tx_ovf_evt = mem_we && is_tx && tx_full && !tx_pop;

    assign rx_push    = rx_valid && rx_ready;
    assign rx_pop_req = mem_re && !mem_we && is_rx;
    assign rx_pop     = rx_pop_req && !rx_empty;
    assign rx_unf_evt = rx_pop_req && rx_empty;

    assign st_we = mem_we && is_st;

    always_ff @(posedge clock) begin
        if (mem_we && is_ram)
            ram[mem_addr[MEM_AW-1:0]] <= mem_wdata;
        if (!reset && tx_push)
            tx_mem[tx_wp] <= mem_wdata;
        if (!reset && rx_push)
            rx_mem[rx_wp] <= rx_data;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            tx_wp  <= '0;
            tx_rp  <= '0;
            tx_cnt <= '0;
        end else begin
            if (tx_push) tx_wp <= tx_wp + PW'(1);
            if (tx_pop)  tx_rp <= tx_rp + PW'(1);
            if (tx_push && !tx_pop)      tx_cnt <= tx_cnt + CW'(1);
            else if (!tx_push && tx_pop) tx_cnt <= tx_cnt - CW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rx_wp  <= '0;
            rx_rp  <= '0;
            rx_cnt <= '0;
        end else begin
            if (rx_push) rx_wp <= rx_wp + PW'(1);
            if (rx_pop)  rx_rp <= rx_rp + PW'(1);
            if (rx_push && !rx_pop)      rx_cnt <= rx_cnt + CW'(1);
            else if (!rx_push && rx_pop) rx_cnt <= rx_cnt - CW'(1);
        end
    end

    // Sticky error flags: a fresh event outranks a write-1-to-clear in the same cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            tx_ovf <= 1'b0;
            rx_unf <= 1'b0;
        end else begin
            if (tx_ovf_evt)                   tx_ovf <= 1'b1;
            else if (st_we && mem_wdata[2])   tx_ovf <= 1'b0;
            if (rx_unf_evt)                   rx_unf <= 1'b1;
            else if (st_we && mem_wdata[3])   rx_unf <= 1'b0;
        end
    end

`ifdef MMIO_TIMER_EN
    logic [WORD_SIZE-1:0] timer;

    // A loaded value already counts the write cycle, so it reads back as value+1 next cycle.
    always_ff @(posedge clock) begin
        if (reset)                timer <= '0;
        else if (mem_we && is_tm) timer <= mem_wdata + 1'b1;
        else                      timer <= timer + 1'b1;
    end

    assign timer_val = timer;
`else
    assign timer_val = '0;
`endif

    always_comb begin
        mem_rdata = '0;
        if (is_ram)
            mem_rdata = ram[mem_addr[MEM_AW-1:0]];
        else if (is_rx)
            mem_rdata = rx_empty ? '0 : rx_mem[rx_rp];
        else if (is_st)
            mem_rdata = {{(WORD_SIZE-4){1'b0}}, rx_unf, tx_ovf, rx_empty, tx_full};
        else if (is_tm)
            mem_rdata = timer_val;
    end

endmodule

// File: tb/tb_data_bus_responder.sv
// Scoreboard bench for data_bus_responder: stimulus queues expected load data and TX words,
// a negedge monitor pops and compares whenever a load strobe or TX handshake is seen.
module tb_data_bus_responder;

    localparam int AS = 18;
    localparam int WS = 18;
    localparam int MS = 1024;
    localparam logic [AS-1:0] B = 18'h3FF00;

    logic          clock;
    logic          reset;
    logic          mem_we;
    logic          mem_re;
    logic [AS-1:0] mem_addr;
    logic [WS-1:0] mem_wdata;
    logic [WS-1:0] mem_rdata;
    logic          tx_valid;
    logic [WS-1:0] tx_data;
    logic          tx_ready;
    logic          rx_valid;
    logic [WS-1:0] rx_data;
    logic          rx_ready;

    int checks = 0;
    int errors = 0;
    logic [WS-1:0] rd_q[$];
    logic [WS-1:0] tx_q[$];

    data_bus_responder #(
        .ADDR_SIZE(AS), .WORD_SIZE(WS), .MEM_SIZE(MS), .FIFO_DEPTH(4), .MMIO_BASE('h3FF00)
    ) dut (
        .clock(clock), .reset(reset),
        .mem_we(mem_we), .mem_re(mem_re), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
        .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_output(input string name, input logic [WS-1:0] act, input logic [WS-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Drives one bus cycle just after the clock edge and queues the load result if it is a load.
    task automatic apply_stimulus(input logic we, input logic re, input logic [AS-1:0] addr,
                                  input logic [WS-1:0] wdata, input logic [WS-1:0] exp);
        @(posedge clock);
        #1;
        mem_we    = we;
        mem_re    = re;
        mem_addr  = addr;
        mem_wdata = wdata;
        if (re) rd_q.push_back(exp);
    endtask

    always @(negedge clock) begin
        if (!reset) begin
            if (mem_re) begin
                if (rd_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_load addr=%h actual=%h required=none", mem_addr, mem_rdata);
                end else begin
                    check_output($sformatf("load@%h", mem_addr), mem_rdata, rd_q.pop_front());
                end
            end
            if (tx_valid && tx_ready) begin
                if (tx_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_tx actual=%h required=none", tx_data);
                end else begin
                    check_output("tx_word", tx_data, tx_q.pop_front());
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL timeout actual=running required=finished");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        reset = 1'b1; mem_we = 1'b0; mem_re = 1'b0; mem_addr = '0; mem_wdata = '0;
        tx_ready = 1'b0; rx_valid = 1'b0; rx_data = '0;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        check_output("reset_tx_valid", WS'(tx_valid), WS'(0));
        check_output("reset_rx_ready", WS'(rx_ready), WS'(1));
        apply_stimulus(0, 1, B + 2, 0, 'b0010);

        $display("[TB] RAM and unmapped reads");
        apply_stimulus(1, 0, 5, 'h2A, 0);
        apply_stimulus(0, 1, 5, 0, 'h2A);
        apply_stimulus(0, 1, MS, 0, 0);
        apply_stimulus(0, 1, B, 0, 0);

        $display("[TB] host pushes 7, 8");
        apply_stimulus(0, 0, 0, 0, 0);
        rx_valid = 1'b1; rx_data = 7;
        apply_stimulus(0, 0, 0, 0, 0);
        rx_data = 8;
        apply_stimulus(0, 0, 0, 0, 0);
        rx_valid = 1'b0;

        $display("[TB] TX overflow and drain");
        for (int i = 1; i <= 5; i++) begin
            apply_stimulus(1, 0, B, WS'(i), 0);
            if (i <= 4) tx_q.push_back(WS'(i));
        end
        apply_stimulus(0, 1, B + 2, 0, 'b0101);
        apply_stimulus(1, 0, B + 2, 'b0100, 0);
        apply_stimulus(0, 1, B + 2, 0, 'b0001);
        apply_stimulus(0, 0, 0, 0, 0);
        tx_ready = 1'b1;
        repeat (4) apply_stimulus(0, 0, 0, 0, 0);
        @(negedge clock);
        check_output("tx_drained_valid", WS'(tx_valid), WS'(0));

        $display("[TB] TX full with same-cycle pop");
        apply_stimulus(1, 0, B, 10, 0);
        tx_ready = 1'b0;
        tx_q.push_back(10);
        for (int i = 11; i <= 13; i++) begin
            apply_stimulus(1, 0, B, WS'(i), 0);
            tx_q.push_back(WS'(i));
        end
        apply_stimulus(1, 0, B, 9, 0);
        tx_ready = 1'b1;
        tx_q.push_back(9);
        repeat (4) apply_stimulus(0, 0, 0, 0, 0);
        apply_stimulus(0, 1, B + 2, 0, 'b0000);
        tx_ready = 1'b0;

        $display("[TB] RX no-strobe and loads");
        repeat (10) apply_stimulus(0, 0, B + 1, 0, 0);
        @(negedge clock);
        check_output("rx_head_no_strobe", mem_rdata, 7);
        apply_stimulus(1, 1, B + 1, 'h3, 7);
        apply_stimulus(0, 1, B + 1, 0, 7);
        apply_stimulus(0, 1, B + 1, 0, 8);
        apply_stimulus(0, 1, B + 1, 0, 0);
        apply_stimulus(0, 1, B + 2, 0, 'b1010);
        apply_stimulus(1, 0, B + 2, 'b1000, 0);
        apply_stimulus(0, 1, B + 2, 0, 'b0010);

        $display("[TB] RX underflow with same-cycle host push");
        apply_stimulus(0, 1, B + 1, 0, 0);
        rx_valid = 1'b1; rx_data = 'h33;
        apply_stimulus(0, 1, B + 2, 0, 'b1000);
        rx_valid = 1'b0;
        apply_stimulus(0, 1, B + 1, 0, 'h33);
        apply_stimulus(1, 0, B + 2, 'b1000, 0);
        apply_stimulus(0, 1, B + 2, 0, 'b0010);

        $display("[TB] timer");
`ifdef MMIO_TIMER_EN
        apply_stimulus(1, 0, B + 3, 100, 0);
        apply_stimulus(0, 0, 0, 0, 0);
        apply_stimulus(0, 0, 0, 0, 0);
        apply_stimulus(0, 1, B + 3, 0, 103);
        apply_stimulus(1, 0, B + 3, 'h3FFFF, 0);
        apply_stimulus(0, 1, B + 3, 0, 0);
`else
        apply_stimulus(1, 0, B + 3, 100, 0);
        apply_stimulus(0, 1, B + 3, 0, 0);
`endif

        $display("[TB] reset mid-transfer");
        apply_stimulus(1, 0, B, 'h44, 0);
        apply_stimulus(0, 0, 0, 0, 0);
        rx_valid = 1'b1; rx_data = 'h55; reset = 1'b1;
        apply_stimulus(0, 0, 0, 0, 0);
        apply_stimulus(0, 0, 0, 0, 0);
        apply_stimulus(0, 0, 0, 0, 0);
        reset = 1'b0; rx_valid = 1'b0;
        @(negedge clock);
        check_output("post_reset_tx_valid", WS'(tx_valid), WS'(0));
        check_output("post_reset_rx_ready", WS'(rx_ready), WS'(1));
        apply_stimulus(0, 1, B + 2, 0, 'b0010);

        apply_stimulus(0, 0, 0, 0, 0);
        repeat (2) @(posedge clock);
        check_output("load_queue_left", WS'(rd_q.size()), WS'(0));
        check_output("tx_queue_left", WS'(tx_q.size()), WS'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
